// File: rtl/pwm_led_ctrl_pkg.sv
// Shared register map and field positions for the bus-mapped PWM LED controller.
package pwm_led_ctrl_pkg;

    localparam int PRESCALE_BITS = 8;

    localparam logic [3:0] ADDR_CTRL     = 4'h0;
    localparam logic [3:0] ADDR_PRESCALE = 4'h1;
    localparam logic [3:0] ADDR_DUTY0    = 4'h2;
    localparam logic [3:0] ADDR_STATUS   = 4'hF;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_INV    = 1;
    localparam int STATUS_WRAP = 0;

    // Duty shadow registers sit contiguously after ADDR_DUTY0, one per channel.
    function automatic logic [3:0] duty_addr(input int ch);
        return ADDR_DUTY0 + 4'(ch);
    endfunction

endpackage

// File: rtl/pwm_led_ctrl_timebase.sv
// Prescaler plus PWM period counter; both are held at zero while disabled.
module pwm_timebase
    import pwm_led_ctrl_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     en,
    input  logic [PRESCALE_BITS-1:0] prescale,
    output logic [PWM_BITS-1:0]      cnt,
    output logic                     wrap_evt
);

    localparam logic [PWM_BITS-1:0] CNT_LAST = PWM_BITS'((2 ** PWM_BITS) - 2);

    logic [PRESCALE_BITS-1:0] pre_cnt;
    logic                     tick;

    assign tick     = en && (pre_cnt == prescale);
    assign wrap_evt = tick && (cnt == CNT_LAST);

    // A counter left above a freshly lowered prescale value restarts instead of running the long way round.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
        end else if (!en || (pre_cnt >= prescale)) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRESCALE_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (tick) begin
            if (wrap_evt) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + PWM_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/pwm_led_ctrl.sv
// Bus-mapped multi-channel PWM LED controller with double-buffered duty registers.
module pwm_led_ctrl
    import pwm_led_ctrl_pkg::*;
#(
    parameter int CHANNELS   = 3,
    parameter int PWM_BITS   = 8,
    parameter int RESET_DUTY = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cs,
    input  logic                we,
    input  logic [3:0]          addr,
    input  logic [7:0]          din,
    output logic [7:0]          dout,
    output logic [CHANNELS-1:0] pwm_o
);

    localparam logic [PWM_BITS-1:0] RST_DUTY = PWM_BITS'(RESET_DUTY);

    logic                     en;
    logic                     inv;
    logic [PRESCALE_BITS-1:0] prescale;
    logic                     wrap_flag;
    logic [PWM_BITS-1:0]      shadow     [CHANNELS];
    logic [PWM_BITS-1:0]      shadow_nxt [CHANNELS];
    logic [PWM_BITS-1:0]      active     [CHANNELS];
    logic [PWM_BITS-1:0]      cnt;
    logic                     wrap_evt;
    logic                     wr_en;
    logic                     rd_en;
    logic [7:0]               rd_data;

    assign wr_en = cs && we;
    assign rd_en = cs && !we;

    pwm_timebase #(
        .PWM_BITS (PWM_BITS)
    ) u_timebase (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .prescale (prescale),
        .cnt      (cnt),
        .wrap_evt (wrap_evt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en       <= 1'b0;
            inv      <= 1'b0;
            prescale <= '0;
        end else if (wr_en) begin
            if (addr == ADDR_CTRL) begin
                en  <= din[CTRL_EN];
                inv <= din[CTRL_INV];
            end
            if (addr == ADDR_PRESCALE) begin
                prescale <= din;
            end
        end
    end

    // Setting wins over a clear that lands in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrap_flag <= 1'b0;
        end else if (wrap_evt) begin
            wrap_flag <= 1'b1;
        end else if (wr_en && (addr == ADDR_STATUS) && din[STATUS_WRAP]) begin
            wrap_flag <= 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            shadow_nxt[i] = shadow[i];
            if (wr_en && (addr == duty_addr(i))) begin
                shadow_nxt[i] = din[PWM_BITS-1:0];
            end
        end
    end

    // Active duty loads from the post-write shadow, so a write in the wrap cycle is not missed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= RST_DUTY;
                active[i] <= RST_DUTY;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= shadow_nxt[i];
                if (!en || wrap_evt) begin
                    active[i] <= shadow_nxt[i];
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_CTRL: begin
                rd_data[CTRL_EN]  = en;
                rd_data[CTRL_INV] = inv;
            end
            ADDR_PRESCALE: rd_data = prescale;
            ADDR_STATUS:   rd_data[STATUS_WRAP] = wrap_flag;
            default: begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (addr == duty_addr(i)) begin
                        rd_data[PWM_BITS-1:0] = shadow[i];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout <= '0;
        end else if (rd_en) begin
            dout <= rd_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_o <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                pwm_o[i] <= ((cnt < active[i]) && en) ^ inv;
            end
        end
    end

endmodule

// File: tb/tb_pwm_led_ctrl.sv
// Self-checking bench for pwm_led_ctrl: register table, directed PWM scenarios and a randomized model run.
module tb_pwm_led_ctrl;
    import pwm_led_ctrl_pkg::*;

    localparam int CH   = 3;
    localparam int MAXV = 255;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          cs      = 1'b0;
    logic          we      = 1'b0;
    logic [3:0]    addr    = '0;
    logic [7:0]    din     = '0;
    logic [7:0]    dout;
    logic [CH-1:0] pwm_o;

    int tests = 0;
    int fails = 0;

    pwm_led_ctrl #(
        .CHANNELS   (CH),
        .PWM_BITS   (8),
        .RESET_DUTY (0)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .cs      (cs),
        .we      (we),
        .addr    (addr),
        .din     (din),
        .dout    (dout),
        .pwm_o   (pwm_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] waddr;
        logic [7:0] wdata;
        logic [3:0] raddr;
        logic [7:0] exp;
    } reg_vec_t;

    reg_vec_t vecs[11];

    // Behavioural reference: counter position is derived arithmetically from cycles since enable.
    int         m_t;
    int         m_p;
    logic       m_en;
    logic       m_inv;
    logic       m_wrap;
    logic [7:0] m_shadow[CH];
    logic [7:0] m_active[CH];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic report_timeout(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic tick_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        cs = 1'b1; we = 1'b1; addr = a; din = d;
        tick_cycle();
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
        cs = 1'b1; we = 1'b0; addr = a;
        tick_cycle();
        cs = 1'b0;
        d = dout;
    endtask

    task automatic do_reset();
        cs = 1'b0; we = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic apply_stimulus(input int idx);
        logic [7:0] r;
        bus_write(vecs[idx].waddr, vecs[idx].wdata);
        bus_read(vecs[idx].raddr, r);
        check_output($sformatf("reg_vec%0d", idx), 32'(r), 32'(vecs[idx].exp));
    endtask

    // Waits for a rising edge on channel ch, then measures high width and full rise-to-rise period.
    task automatic measure_pulse(input int ch, input string name, output int width, output int period);
        logic prev;
        logic found;
        int   n;
        width = 0; period = 0; found = 1'b0;
        prev = pwm_o[ch];
        for (n = 0; n < 3000; n++) begin
            tick_cycle();
            if (!prev && pwm_o[ch]) begin
                found = 1'b1;
                break;
            end
            prev = pwm_o[ch];
        end
        if (!found) begin
            report_timeout({name, "_rise"});
            return;
        end
        width = 1; period = 1; found = 1'b0;
        for (n = 0; n < 3000; n++) begin
            tick_cycle();
            period++;
            if (pwm_o[ch]) width++;
            else begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            report_timeout({name, "_fall"});
            return;
        end
        found = 1'b0;
        for (n = 0; n < 3000; n++) begin
            tick_cycle();
            if (pwm_o[ch]) begin
                found = 1'b1;
                break;
            end
            period++;
        end
        if (!found) report_timeout({name, "_next_rise"});
    endtask

    function automatic logic [7:0] rand_duty();
        case ($urandom_range(0, 7))
            0:       return 8'd0;
            1:       return 8'd255;
            2:       return 8'd1;
            3:       return 8'd254;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic model_init();
        m_t = 0; m_p = 0; m_en = 1'b0; m_inv = 1'b0; m_wrap = 1'b0;
        for (int i = 0; i < CH; i++) begin
            m_shadow[i] = 8'd0;
            m_active[i] = 8'd0;
        end
    endtask

    task automatic model_cycle(input logic c, input logic w, input logic [3:0] a, input logic [7:0] d);
        int            cnt_now;
        logic          tk;
        logic          wrap_now;
        logic          rd;
        logic [7:0]    exp_rd;
        logic [CH-1:0] exp_pwm;
        logic          nxt_en;
        logic          nxt_inv;
        int            nxt_p;
        logic          clr;
        rd = c && !w;
        exp_rd = 8'h00;
        if (a == 4'h0)      exp_rd = {6'b0, m_inv, m_en};
        else if (a == 4'h1) exp_rd = 8'(m_p);
        else if (a == 4'hF) exp_rd = {7'b0, m_wrap};
        else if (int'(a) >= 2 && int'(a) < 2 + CH) exp_rd = m_shadow[int'(a) - 2];

        cnt_now  = m_en ? ((m_t / (m_p + 1)) % MAXV) : 0;
        tk       = m_en && ((m_t % (m_p + 1)) == m_p);
        wrap_now = tk && (cnt_now == MAXV - 1);
        for (int i = 0; i < CH; i++) exp_pwm[i] = ((cnt_now < int'(m_active[i])) && m_en) ^ m_inv;

        nxt_en = m_en; nxt_inv = m_inv; nxt_p = m_p; clr = 1'b0;
        if (c && w) begin
            if (a == 4'h0) begin
                nxt_en = d[0];
                nxt_inv = d[1];
            end else if (a == 4'h1) begin
                nxt_p = int'(d);
            end else if (a == 4'hF) begin
                clr = d[0];
            end else if (int'(a) >= 2 && int'(a) < 2 + CH) begin
                m_shadow[int'(a) - 2] = d;
            end
        end
        if (!m_en || wrap_now) begin
            for (int i = 0; i < CH; i++) m_active[i] = m_shadow[i];
        end
        if (wrap_now) m_wrap = 1'b1;
        else if (clr) m_wrap = 1'b0;
        m_t = m_en ? m_t + 1 : 0;
        m_en = nxt_en; m_inv = nxt_inv; m_p = nxt_p;

        cs = c; we = w; addr = a; din = d;
        tick_cycle();
        cs = 1'b0; we = 1'b0;
        check_output("rand_pwm", 32'(pwm_o), 32'(exp_pwm));
        if (rd) check_output("rand_read", 32'(dout), 32'(exp_rd));
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] r;
        logic [3:0] rst_addrs[4];
        int         c0, c1, c2, n, width, period, first_high;
        logic       found;

        vecs[0]  = '{ADDR_PRESCALE, 8'hA5, ADDR_PRESCALE, 8'hA5};
        vecs[1]  = '{4'h2,          8'h40, 4'h2,          8'h40};
        vecs[2]  = '{4'h3,          8'h00, 4'h3,          8'h00};
        vecs[3]  = '{4'h4,          8'hFF, 4'h4,          8'hFF};
        vecs[4]  = '{4'h5,          8'h77, 4'h5,          8'h00};
        vecs[5]  = '{ADDR_CTRL,     8'hFC, ADDR_CTRL,     8'h00};
        vecs[6]  = '{ADDR_CTRL,     8'h02, ADDR_CTRL,     8'h02};
        vecs[7]  = '{ADDR_CTRL,     8'h00, ADDR_CTRL,     8'h00};
        vecs[8]  = '{ADDR_STATUS,   8'h01, ADDR_STATUS,   8'h00};
        vecs[9]  = '{4'hE,          8'h12, 4'h2,          8'h40};
        vecs[10] = '{ADDR_PRESCALE, 8'h00, 4'hE,          8'h00};
        rst_addrs[0] = 4'h0; rst_addrs[1] = 4'h1; rst_addrs[2] = 4'h2; rst_addrs[3] = 4'hF;

        do_reset();
        check_output("reset_pwm", 32'(pwm_o), 32'h0);
        check_output("reset_dout", 32'(dout), 32'h0);
        for (int i = 0; i < 4; i++) begin
            bus_read(rst_addrs[i], r);
            check_output($sformatf("reset_read_%0h", rst_addrs[i]), 32'(r), 32'h0);
        end

        for (int i = 0; i < 11; i++) apply_stimulus(i);

        // Basic duty: any window spanning whole periods holds a fixed number of high cycles.
        bus_write(ADDR_PRESCALE, 8'h00);
        bus_write(4'h2, 8'h40);
        bus_write(4'h3, 8'h00);
        bus_write(4'h4, 8'hFF);
        bus_write(ADDR_CTRL, 8'h01);
        repeat (10) tick_cycle();
        c0 = 0; c1 = 0; c2 = 0;
        for (int i = 0; i < 2 * MAXV; i++) begin
            tick_cycle();
            c0 += int'(pwm_o[0]);
            c1 += int'(pwm_o[1]);
            c2 += int'(pwm_o[2]);
        end
        check_output("basic_ch0_high", 32'(c0), 32'd128);
        check_output("basic_ch1_high", 32'(c1), 32'd0);
        check_output("basic_ch2_high", 32'(c2), 32'd510);

        bus_write(ADDR_STATUS, 8'h01);
        found = 1'b0;
        for (int i = 0; i < 600; i++) begin
            bus_read(ADDR_STATUS, r);
            if (r[0]) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) report_timeout("wrap_first");
        bus_write(ADDR_STATUS, 8'h01);
        n = 1; found = 1'b0;
        for (int i = 0; i < 600; i++) begin
            bus_read(ADDR_STATUS, r);
            n++;
            if (r[0]) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) report_timeout("wrap_period");
        else check_output("wrap_period", 32'(n), 32'd255);

        // Double buffering: a mid-pulse write must not disturb the pulse in flight.
        found = 1'b0;
        r = pwm_o[0] ? 8'h01 : 8'h00;
        for (int i = 0; i < 600; i++) begin
            tick_cycle();
            if (!r[0] && pwm_o[0]) begin
                found = 1'b1;
                break;
            end
            r = pwm_o[0] ? 8'h01 : 8'h00;
        end
        if (!found) report_timeout("dbuf_rise");
        width = 1;
        repeat (29) begin
            tick_cycle();
            width += int'(pwm_o[0]);
        end
        bus_write(4'h2, 8'h10);
        width += int'(pwm_o[0]);
        for (int i = 0; i < 300 && pwm_o[0]; i++) begin
            tick_cycle();
            width += int'(pwm_o[0]);
        end
        check_output("dbuf_current_width", 32'(width), 32'd64);
        measure_pulse(0, "dbuf_next", width, period);
        check_output("dbuf_next_width", 32'(width), 32'd16);
        check_output("dbuf_next_period", 32'(period), 32'd255);

        bus_write(ADDR_CTRL, 8'h00);
        bus_write(ADDR_PRESCALE, 8'h03);
        bus_write(4'h2, 8'h80);
        bus_write(ADDR_CTRL, 8'h01);
        measure_pulse(0, "prescale", width, period);
        check_output("prescale_width", 32'(width), 32'd512);
        check_output("prescale_period", 32'(period), 32'd1020);

        // Invert and disable, then re-enable: counter restarts from zero.
        bus_write(ADDR_CTRL, 8'h00);
        bus_write(ADDR_PRESCALE, 8'h00);
        bus_write(4'h2, 8'h40);
        bus_write(ADDR_CTRL, 8'h02);
        tick_cycle();
        check_output("inv_disabled", 32'(pwm_o), 32'h7);
        bus_write(ADDR_CTRL, 8'h03);
        check_output("inv_enable_latency", 32'(pwm_o), 32'h7);
        c0 = 0; c1 = 0; c2 = 0; first_high = -1;
        for (int i = 0; i < MAXV; i++) begin
            tick_cycle();
            if (!pwm_o[0]) c0++;
            else if (first_high < 0) first_high = i;
            c1 += int'(pwm_o[1]);
            c2 += int'(pwm_o[2]);
        end
        check_output("inv_ch0_low", 32'(c0), 32'd64);
        check_output("inv_ch0_first_high", 32'(first_high), 32'd64);
        check_output("inv_ch1_high", 32'(c1), 32'd255);
        check_output("inv_ch2_high", 32'(c2), 32'd0);

        // Clear landing in the wrap cycle loses to the set.
        bus_write(ADDR_CTRL, 8'h00);
        bus_write(ADDR_STATUS, 8'h01);
        bus_write(ADDR_CTRL, 8'h01);
        repeat (254) tick_cycle();
        bus_write(ADDR_STATUS, 8'h01);
        bus_read(ADDR_STATUS, r);
        check_output("wrap_set_wins", 32'(r[0]), 32'd1);
        bus_write(ADDR_STATUS, 8'h01);
        bus_read(ADDR_STATUS, r);
        check_output("wrap_cleared", 32'(r[0]), 32'd0);

        bus_write(ADDR_CTRL, 8'h00);
        bus_write(ADDR_CTRL, 8'h01);
        repeat (254) tick_cycle();
        bus_write(4'h2, 8'h10);
        c0 = 0;
        for (int i = 0; i < MAXV; i++) begin
            tick_cycle();
            c0 += int'(pwm_o[0]);
        end
        check_output("duty_in_wrap_cycle", 32'(c0), 32'd16);

        repeat (20) tick_cycle();
        bus_read(4'h4, r);
        check_output("pre_reset_ch2", 32'(pwm_o[2]), 32'd1);
        check_output("pre_reset_dout", 32'(r), 32'hFF);
        #3;
        reset_n = 1'b0;
        #1;
        check_output("async_reset_pwm", 32'(pwm_o), 32'h0);
        check_output("async_reset_dout", 32'(dout), 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        bus_read(4'h2, r);
        check_output("post_reset_duty0", 32'(r), 32'h0);

        // Randomized run against the reference model.
        do_reset();
        model_init();
        for (int run = 0; run < 4; run++) begin
            model_cycle(1'b1, 1'b1, 4'h0, 8'h00);
            model_cycle(1'b1, 1'b1, 4'h1, 8'($urandom_range(0, 2)));
            for (int ch = 0; ch < CH; ch++) model_cycle(1'b1, 1'b1, 4'(2 + ch), rand_duty());
            model_cycle(1'b1, 1'b1, 4'h0, {6'b0, 1'($urandom_range(0, 1)), 1'b1});
            for (int i = 0; i < 1600; i++) begin
                n = int'($urandom_range(0, 99));
                if (n < 6)       model_cycle(1'b1, 1'b1, 4'(2 + $urandom_range(0, CH - 1)), rand_duty());
                else if (n < 9)  model_cycle(1'b1, 1'b0, 4'hF, 8'h00);
                else if (n < 11) model_cycle(1'b1, 1'b1, 4'hF, 8'h01);
                else if (n < 12) model_cycle(1'b1, 1'b0, 4'h0, 8'h00);
                else if (n < 13) model_cycle(1'b1, 1'b0, 4'(2 + $urandom_range(0, CH - 1)), 8'h00);
                else             model_cycle(1'b0, 1'b0, 4'h0, 8'h00);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
